// File: rtl/roberts_edge.sv
// roberts_edge: 3-stage valid/ready Roberts-cross edge magnitude with per-frame pixel counting
// Ports:
//   clk, nrst (async, active-low), clear (sync flush of valids and pix_count)
//   win_valid/win_ready, w_1..w_4 : 2x2 window in (top-left, top-right, bottom-left, bottom-right)
//   pix_valid/out_ready, pix_out   : edge magnitude out
//   pix_count, frame_done          : pixels delivered this frame, one-cycle end-of-frame pulse
//   thresh                         : binarisation threshold, only when ROBERTS_THRESH_EN is defined
module roberts_edge #(
  parameter logic [15:0] FRAME_PIXELS = 16'd16384
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        win_valid,
  input  logic [7:0]  w_1,
  input  logic [7:0]  w_2,
  input  logic [7:0]  w_3,
  input  logic [7:0]  w_4,
  output logic        win_ready,
  input  logic        out_ready,
  output logic        pix_valid,
  output logic [7:0]  pix_out,
  output logic [15:0] pix_count,
  output logic        frame_done
`ifdef ROBERTS_THRESH_EN
  ,
  input  logic [7:0]  thresh
`endif
);
  logic       v1, v2, v3, adv, hs;
  logic [7:0] r_1, r_2, r_3, r_4, d_a, d_b, mag, s3_d;
  logic [8:0] sum;
  // whole pipeline moves in lockstep; bubbles shift too
  assign adv = !v3 || out_ready;
  assign hs = v3 && out_ready;
  assign win_ready = adv && !clear;
  assign pix_valid = v3;
  assign sum = {1'b0, d_a} + {1'b0, d_b};
  assign mag = sum[8] ? 8'hFF : sum[7:0];
`ifdef ROBERTS_THRESH_EN
  assign s3_d = (mag >= thresh) ? 8'hFF : 8'h00;
`else
  assign s3_d = mag;
`endif
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      {v1, v2, v3} <= 3'b000;
      {r_1, r_2, r_3, r_4} <= '0;
      {d_a, d_b} <= '0;
      pix_out <= 8'h00;
      pix_count <= 16'd0;
      frame_done <= 1'b0;
    end else if (clear) begin
      {v1, v2, v3} <= 3'b000;
      pix_count <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs && (pix_count == FRAME_PIXELS - 16'd1);
      if (hs)
        pix_count <= (pix_count == FRAME_PIXELS - 16'd1) ? 16'd0 : pix_count + 16'd1;
      if (adv) begin
        v1 <= win_valid;
        v2 <= v1;
        v3 <= v2;
        {r_1, r_2, r_3, r_4} <= {w_1, w_2, w_3, w_4};
        // larger minus smaller so the difference never wraps
        d_a <= (r_1 > r_4) ? r_1 - r_4 : r_4 - r_1;
        d_b <= (r_2 > r_3) ? r_2 - r_3 : r_3 - r_2;
        pix_out <= s3_d;
      end
    end
  end
endmodule

// File: tb/tb_roberts_edge.sv
// tb_roberts_edge: randomized and directed checks of roberts_edge against a queue-based model
module tb_roberts_edge;
  localparam int FP = 4;
  logic clk = 0, nrst, clear, win_valid, out_ready;
  logic [7:0] w1, w2, w3, w4, thresh;
  logic win_ready, pix_valid, frame_done;
  logic [7:0] pix_out;
  logic [15:0] pix_count;
  int nvec = 0, nerr = 0;

  roberts_edge #(.FRAME_PIXELS(16'(FP))) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .win_valid(win_valid),
    .w_1(w1), .w_2(w2), .w_3(w3), .w_4(w4), .win_ready(win_ready),
    .out_ready(out_ready), .pix_valid(pix_valid), .pix_out(pix_out),
    .pix_count(pix_count), .frame_done(frame_done)
`ifdef ROBERTS_THRESH_EN
    , .thresh(thresh)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  function automatic logic [7:0] mag(input logic [7:0] a, b, c, d);
    int s;
    s = (a > d ? a - d : d - a) + (b > c ? b - c : c - b);
    return s > 255 ? 8'hFF : 8'(s);
  endfunction

  function automatic logic [7:0] fin(input logic [7:0] m);
`ifdef ROBERTS_THRESH_EN
    return m >= thresh ? 8'hFF : 8'h00;
`else
    return m;
`endif
  endfunction

  // model: every accepted window ages by one per advancing edge; age 3 means it is on the output
  typedef struct {logic [7:0] val; int age;} ent_t;
  ent_t q[$];
  int cnt = 0;
  bit fd = 0, m_ev, m_hs, m_adv;

  always @(negedge clk) begin
    if (!nrst) begin
      q.delete();
      cnt = 0;
      fd = 0;
    end
    m_ev = q.size() > 0 && q[0].age >= 3;
    chk("pix_valid", pix_valid, m_ev);
    if (m_ev) chk("pix_out", pix_out, q[0].val);
    if (!nrst) chk("pix_out_rst", pix_out, 0);
    chk("win_ready", win_ready, (!m_ev || out_ready) && !clear);
    chk("pix_count", pix_count, cnt);
    chk("frame_done", frame_done, fd);
    if (nrst) begin
      if (clear) begin
        q.delete();
        cnt = 0;
        fd = 0;
      end else begin
        m_hs = m_ev && out_ready;
        m_adv = !m_ev || out_ready;
        fd = m_hs && cnt == FP - 1;
        if (m_hs) begin
          cnt = (cnt == FP - 1) ? 0 : cnt + 1;
          void'(q.pop_front());
        end
        if (m_adv) begin
          for (int i = 0; i < q.size(); i++) begin
            q[i].age++;
            if (q[i].age == 3) q[i].val = fin(q[i].val);
          end
          if (win_valid) q.push_back('{val: mag(w1, w2, w3, w4), age: 1});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, b, c, d);
    win_valid = 1;
    {w1, w2, w3, w4} = {a, b, c, d};
  endtask

  int sent, k;
  bit hs_prev, done;
  logic [7:0] held;
  logic [15:0] got_cnt[6];
  logic got_fd[6];
  int exp_cnt[6] = '{1, 2, 3, 0, 1, 2};
  int exp_fd[6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    nrst = 0; clear = 0; win_valid = 0; out_ready = 1; thresh = 0;
    {w1, w2, w3, w4} = '0;
    #2;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_out", pix_out, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_ready", win_ready, 1);
    cyc(); cyc();
    nrst = 1;
`ifndef ROBERTS_THRESH_EN
    cyc(); send(200, 50, 10, 20);
    cyc(); win_valid = 0;
    @(negedge clk); chk("lat_n1", pix_valid, 0);
    cyc(); @(negedge clk); chk("lat_n2", pix_valid, 0);
    cyc(); @(negedge clk); chk("lat_n3_valid", pix_valid, 1); chk("lat_n3_out", pix_out, 220);
    cyc(); @(negedge clk); chk("lat_n4", pix_valid, 0);
    cyc(); send(255, 0, 255, 0);
    cyc(); send(77, 77, 77, 77);
    cyc(); win_valid = 0;
    cyc(); @(negedge clk); chk("sat_ff", pix_out, 8'hFF);
    cyc(); @(negedge clk); chk("flat_zero", pix_out, 0); chk("flat_valid", pix_valid, 1);
`else
    thresh = 100;
    cyc(); send(99, 0, 0, 0);
    cyc(); send(100, 0, 0, 0);
    cyc(); send(200, 100, 0, 0);
    cyc(); win_valid = 0;
    @(negedge clk);
    cyc(); @(negedge clk); chk("th_99", pix_out, 8'h00);
    cyc(); @(negedge clk); chk("th_100", pix_out, 8'hFF);
    cyc(); @(negedge clk); chk("th_300", pix_out, 8'hFF);
`endif
    // backpressure: 5 windows, out_ready low for cycles 4..7
    sent = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      out_ready = !(i >= 4 && i <= 7);
      if (sent < 5) send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      else win_valid = 0;
      @(negedge clk);
      if (win_valid && win_ready) sent++;
      if (i == 6) chk("stall_win_ready", win_ready, 0);
      if (i == 5) held = pix_out;
      if (i == 7) chk("stall_stable", pix_out, held);
    end
    chk("bp_sent", sent, 5);
    win_valid = 0; out_ready = 1;
    // frame wrap
    cyc(); clear = 1;
    cyc(); clear = 0;
    k = 0; hs_prev = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i < 6) send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      else win_valid = 0;
      @(negedge clk);
      if (hs_prev && k < 6) begin
        got_cnt[k] = pix_count;
        got_fd[k] = frame_done;
        k++;
      end
      hs_prev = pix_valid && out_ready;
    end
    chk("wrap_hs", k, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wrap_cnt%0d", i), got_cnt[i], exp_cnt[i]);
      chk($sformatf("wrap_fd%0d", i), got_fd[i], exp_fd[i]);
    end
    // clear colliding with the wrapping handshake, pipeline full
    cyc(); clear = 1;
    cyc(); clear = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (pix_count == FP - 1 && pix_valid) begin
        clear = 1;
        send(1, 2, 3, 4);
        @(negedge clk); chk("clr_win_ready", win_ready, 0);
        cyc(); clear = 0; win_valid = 0;
        @(negedge clk);
        chk("clr_pix_valid", pix_valid, 0);
        chk("clr_pix_count", pix_count, 0);
        chk("clr_frame_done", frame_done, 0);
        done = 1;
      end else begin
        send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        cyc();
      end
    end
    chk("clr_reached", done, 1);
    // async reset mid-stream
    for (int i = 0; i < 5; i++) begin
      cyc(); send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    @(posedge clk); #3;
    win_valid = 0;
    nrst = 0;
    #1;
    chk("arst_pix_valid", pix_valid, 0);
    chk("arst_pix_count", pix_count, 0);
    chk("arst_pix_out", pix_out, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_win_ready", win_ready, 1);
    cyc(); cyc();
    nrst = 1;
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc();
      win_valid = ($urandom % 4) != 0;
      {w1, w2, w3, w4} = $urandom;
      out_ready = ($urandom % 3) != 0;
      clear = ($urandom % 50) == 0;
      thresh = 8'($urandom);
    end
    clear = 0; win_valid = 0; out_ready = 1;
    repeat (6) cyc();
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
